// File: rtl/multicycle_ctrl.sv
// Multicycle processor main controller.
// A Moore state machine sequences each instruction through fetch, decode and
// class-specific execute/memory/writeback states, drives the datapath
// selects and strobes from the current state, and counts retired
// instructions. The opcode is sampled from DECODE onward.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rstN,
    input  logic [6:0]  op,
    input  logic        memReady,
    output logic        memReq,
    output logic        adrSrc,
    output logic        irWrite,
    output logic        pcUpdate,
    output logic        branch,
    output logic        regWrite,
    output logic        memWrite,
    output logic [1:0]  resSrc,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  aluOp,
    output logic [1:0]  immSrc,
    output logic [3:0]  state,
    output logic        done,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] instret_reg;
    logic        op_supported;

    // Opcodes this controller knows how to sequence.
    always_comb begin
        op_supported = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_supported = 1'b1;
            default:                                  op_supported = 1'b0;
        endcase
    end

    // Next-state selection; memory states stall until memReady, and any
    // unused encoding falls back to FETCH.
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:    state_next = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = memReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = memReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // State register and retired-instruction counter, both cleared by reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_reg   <= S_FETCH;
            instret_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (done) begin
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    // Moore output decode; everything is held at zero while reset is low so
    // the datapath sees no strobe during a reset cycle.
    always_comb begin
        memReq   = 1'b0;
        adrSrc   = 1'b0;
        irWrite  = 1'b0;
        pcUpdate = 1'b0;
        branch   = 1'b0;
        regWrite = 1'b0;
        memWrite = 1'b0;
        resSrc   = 2'b00;
        aluSrcA  = 2'b00;
        aluSrcB  = 2'b00;
        aluOp    = 2'b00;
        immSrc   = 2'b00;
        done     = 1'b0;
        illegal  = 1'b0;
        if (rstN) begin
            case (op)
                OP_SW:   immSrc = 2'b01;
                OP_BEQ:  immSrc = 2'b10;
                OP_JAL:  immSrc = 2'b11;
                default: immSrc = 2'b00;
            endcase
            case (state_reg)
                S_FETCH: begin
                    memReq   = 1'b1;
                    aluSrcB  = 2'b10;
                    resSrc   = 2'b10;
                    irWrite  = memReady;
                    pcUpdate = memReady;
                end
                S_DECODE: begin
                    aluSrcA = 2'b01;
                    aluSrcB = 2'b01;
                    illegal = ~op_supported;
                end
                S_MEMADR: begin
                    aluSrcA = 2'b10;
                    aluSrcB = 2'b01;
                end
                S_MEMREAD: begin
                    memReq = 1'b1;
                    adrSrc = 1'b1;
                end
                S_MEMWB: begin
                    resSrc   = 2'b01;
                    regWrite = 1'b1;
                    done     = 1'b1;
                end
                S_MEMWRITE: begin
                    memReq   = 1'b1;
                    adrSrc   = 1'b1;
                    memWrite = 1'b1;
                    done     = memReady;
                end
                S_EXECUTER: begin
                    aluSrcA = 2'b10;
                    aluOp   = 2'b10;
                end
                S_EXECUTEI: begin
                    aluSrcA = 2'b10;
                    aluSrcB = 2'b01;
                    aluOp   = 2'b10;
                end
                S_ALUWB: begin
                    regWrite = 1'b1;
                    done     = 1'b1;
                end
                S_BEQ: begin
                    aluSrcA = 2'b10;
                    aluOp   = 2'b01;
                    branch  = 1'b1;
                    done    = 1'b1;
                end
                S_JAL: begin
                    aluSrcA  = 2'b01;
                    aluSrcB  = 2'b10;
                    pcUpdate = 1'b1;
                end
                default: begin
                    memReq = 1'b0;
                end
            endcase
        end
    end

    assign state   = state_reg;
    assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level reference model predicts
// every output on every cycle, and directed scenarios add literal checks.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rstN;
    logic [6:0]  op;
    logic        memReady;
    logic        memReq, adrSrc, irWrite, pcUpdate, branch, regWrite, memWrite;
    logic [1:0]  resSrc, aluSrcA, aluSrcB, aluOp, immSrc;
    logic [3:0]  state;
    logic        done, illegal;
    logic [31:0] instret;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    int n_vec = 0;
    int n_err = 0;

    multicycle_ctrl dut (
        .clk(clk), .rstN(rstN), .op(op), .memReady(memReady),
        .memReq(memReq), .adrSrc(adrSrc), .irWrite(irWrite), .pcUpdate(pcUpdate),
        .branch(branch), .regWrite(regWrite), .memWrite(memWrite),
        .resSrc(resSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .immSrc(immSrc), .state(state), .done(done), .illegal(illegal),
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct packed {
        logic       memReq, adrSrc, irWrite, pcUpdate, branch, regWrite, memWrite, done, illegal;
        logic [1:0] resSrc, aluSrcA, aluSrcB, aluOp, immSrc;
    } outs_t;

    // Reference output table, keyed by the architectural step number.
    function automatic outs_t model_outs(input int st, input logic rdy, input logic [6:0] opc, input logic rst_n);
        outs_t o;
        o = '0;
        if (!rst_n) return o;
        if (opc == SW)  o.immSrc = 2'b01;
        if (opc == BEQ) o.immSrc = 2'b10;
        if (opc == JAL) o.immSrc = 2'b11;
        if (st == 0)  begin o.memReq = 1; o.aluSrcB = 2; o.resSrc = 2; o.irWrite = rdy; o.pcUpdate = rdy; end
        if (st == 1)  begin o.aluSrcA = 1; o.aluSrcB = 1;
                            o.illegal = !(opc inside {LW, SW, RT, IT, BEQ, JAL}); end
        if (st == 2)  begin o.aluSrcA = 2; o.aluSrcB = 1; end
        if (st == 3)  begin o.memReq = 1; o.adrSrc = 1; end
        if (st == 4)  begin o.resSrc = 1; o.regWrite = 1; o.done = 1; end
        if (st == 5)  begin o.memReq = 1; o.adrSrc = 1; o.memWrite = 1; o.done = rdy; end
        if (st == 6)  begin o.aluSrcA = 2; o.aluOp = 2; end
        if (st == 7)  begin o.aluSrcA = 2; o.aluSrcB = 1; o.aluOp = 2; end
        if (st == 8)  begin o.regWrite = 1; o.done = 1; end
        if (st == 9)  begin o.aluSrcA = 2; o.aluOp = 1; o.branch = 1; o.done = 1; end
        if (st == 10) begin o.aluSrcA = 1; o.aluSrcB = 2; o.pcUpdate = 1; end
        return o;
    endfunction

    // Model state: current step, remaining steps of this instruction, count.
    int          m_st = 0;
    int          m_path[$];
    logic [31:0] m_ret = 0;
    bit          model_on = 0;

    // Advance the model one clock: an instruction is a path of steps decided
    // at decode; steps 0, 3 and 5 wait for memReady.
    always @(posedge clk) begin
        outs_t e;
        if (!rstN) begin
            m_st = 0; m_ret = 0; m_path.delete(); model_on = 1;
        end else if (model_on) begin
            e = model_outs(m_st, memReady, op, rstN);
            if (e.done) m_ret = m_ret + 1;
            if (m_st == 1) begin
                m_path.delete();
                if (op == LW)  m_path = '{2, 3, 4};
                if (op == SW)  m_path = '{2, 5};
                if (op == RT)  m_path = '{6, 8};
                if (op == IT)  m_path = '{7, 8};
                if (op == BEQ) m_path = '{9};
                if (op == JAL) m_path = '{10, 8};
            end
            if (m_st == 0) begin
                if (memReady) m_st = 1;
            end else if ((m_st == 3 || m_st == 5) && !memReady) begin
                m_st = m_st;
            end else begin
                m_st = (m_path.size() > 0) ? m_path.pop_front() : 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        outs_t e;
        if (model_on) begin
            e = model_outs(m_st, memReady, op, rstN);
            chk("state", {28'd0, state}, m_st);
            chk("instret", instret, m_ret);
            chk("memReq", {31'd0, memReq}, {31'd0, e.memReq});
            chk("adrSrc", {31'd0, adrSrc}, {31'd0, e.adrSrc});
            chk("irWrite", {31'd0, irWrite}, {31'd0, e.irWrite});
            chk("pcUpdate", {31'd0, pcUpdate}, {31'd0, e.pcUpdate});
            chk("branch", {31'd0, branch}, {31'd0, e.branch});
            chk("regWrite", {31'd0, regWrite}, {31'd0, e.regWrite});
            chk("memWrite", {31'd0, memWrite}, {31'd0, e.memWrite});
            chk("done", {31'd0, done}, {31'd0, e.done});
            chk("illegal", {31'd0, illegal}, {31'd0, e.illegal});
            chk("resSrc", {30'd0, resSrc}, {30'd0, e.resSrc});
            chk("aluSrcA", {30'd0, aluSrcA}, {30'd0, e.aluSrcA});
            chk("aluSrcB", {30'd0, aluSrcB}, {30'd0, e.aluSrcB});
            chk("aluOp", {30'd0, aluOp}, {30'd0, e.aluOp});
            chk("immSrc", {30'd0, immSrc}, {30'd0, e.immSrc});
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    // Directed scenarios with hand-computed literal expectations.
    initial begin
        rstN = 1'b0; memReady = 1'b0; op = 7'd0;
        next_cyc();
        chk("lit_rst_state", {28'd0, state}, 0);
        chk("lit_rst_instret", instret, 0);
        chk("lit_rst_memReq", {31'd0, memReq}, 0);
        next_cyc();
        rstN = 1'b1; memReady = 1'b1; op = LW; #1;
        chk("lit_post_rst_memReq", {31'd0, memReq}, 1);
        chk("lit_post_rst_aluSrcB", {30'd0, aluSrcB}, 2);
        chk("lit_post_rst_irWrite", {31'd0, irWrite}, 1);

        // lw, no wait: 0,1,2,3,4,0
        next_cyc(); chk("lit_lw_s1", {28'd0, state}, 1);
        next_cyc(); chk("lit_lw_s2", {28'd0, state}, 2);
        next_cyc(); chk("lit_lw_s3", {28'd0, state}, 3);
                    chk("lit_lw_regWrite3", {31'd0, regWrite}, 0);
        next_cyc(); chk("lit_lw_s4", {28'd0, state}, 4);
                    chk("lit_lw_regWrite4", {31'd0, regWrite}, 1);
                    chk("lit_lw_done", {31'd0, done}, 1);
        next_cyc(); chk("lit_lw_s0", {28'd0, state}, 0);
                    chk("lit_lw_instret", instret, 1);

        // sw with memReady low for the first three MEMWRITE cycles
        op = SW;
        next_cyc(); chk("lit_sw_immSrc", {30'd0, immSrc}, 1);
        next_cyc();
        next_cyc(); memReady = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cyc();
            chk("lit_sw_hold_state", {28'd0, state}, 5);
            chk("lit_sw_hold_memWrite", {31'd0, memWrite}, 1);
            chk("lit_sw_hold_done", {31'd0, done}, 0);
        end
        next_cyc(); memReady = 1'b1; #1;
        chk("lit_sw_rdy_state", {28'd0, state}, 5);
        chk("lit_sw_rdy_done", {31'd0, done}, 1);
        next_cyc(); chk("lit_sw_instret", instret, 2);

        // beq: 0,1,9,0
        op = BEQ;
        next_cyc();
        next_cyc(); chk("lit_beq_state", {28'd0, state}, 9);
                    chk("lit_beq_branch", {31'd0, branch}, 1);
                    chk("lit_beq_aluOp", {30'd0, aluOp}, 1);
                    chk("lit_beq_immSrc", {30'd0, immSrc}, 2);
        next_cyc(); chk("lit_beq_instret", instret, 3);

        // jal: 0,1,10,8,0
        op = JAL; #1;
        chk("lit_jal_fetch_pcUpdate", {31'd0, pcUpdate}, 1);
        next_cyc();
        next_cyc(); chk("lit_jal_state", {28'd0, state}, 10);
                    chk("lit_jal_pcUpdate", {31'd0, pcUpdate}, 1);
        next_cyc(); chk("lit_jal_aluwb", {28'd0, state}, 8);
                    chk("lit_jal_regWrite", {31'd0, regWrite}, 1);
        next_cyc(); chk("lit_jal_instret", instret, 4);

        // unsupported opcode
        op = BAD;
        next_cyc(); chk("lit_bad_illegal", {31'd0, illegal}, 1);
                    chk("lit_bad_done", {31'd0, done}, 0);
        next_cyc(); chk("lit_bad_state", {28'd0, state}, 0);
                    chk("lit_bad_instret", instret, 4);

        // FETCH stall
        memReady = 1'b0; #1;
        chk("lit_fetch_stall_irWrite", {31'd0, irWrite}, 0);
        next_cyc(); chk("lit_fetch_stall_state", {28'd0, state}, 0);
        memReady = 1'b1;

        // R-type then I-type
        op = RT;
        next_cyc();
        next_cyc(); chk("lit_r_aluOp", {30'd0, aluOp}, 2);
        next_cyc();
        next_cyc(); chk("lit_r_instret", instret, 5);
        op = IT;
        next_cyc();
        next_cyc(); chk("lit_i_state", {28'd0, state}, 7);
        next_cyc();
        next_cyc(); chk("lit_i_instret", instret, 6);

        // reset while in EXECUTER
        op = RT;
        next_cyc();
        next_cyc(); rstN = 1'b0; #1;
        chk("lit_rst_exec_regWrite", {31'd0, regWrite}, 0);
        chk("lit_rst_exec_aluOp", {30'd0, aluOp}, 0);
        next_cyc(); chk("lit_rst_exec_state", {28'd0, state}, 0);
                    chk("lit_rst_exec_instret", instret, 0);
                    chk("lit_rst_exec_regWrite2", {31'd0, regWrite}, 0);
        rstN = 1'b1; #1;
        chk("lit_rst_exec_release", {31'd0, memReq}, 1);

        // reset while waiting in MEMREAD
        op = LW;
        next_cyc(); next_cyc(); next_cyc();
        memReady = 1'b0;
        next_cyc(); chk("lit_memread_wait", {28'd0, state}, 3);
        rstN = 1'b0;
        next_cyc(); chk("lit_rst_wait_state", {28'd0, state}, 0);
        rstN = 1'b1; memReady = 1'b1;
        repeat (5) next_cyc();
        chk("lit_lw_after_rst_instret", instret, 1);

        repeat (2) next_cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state changes on its rising edge
- rstN  in  1  synchronous, active-low reset, sampled on rising clk
- op  in  7  opcode from instruction register, valid from DECODE onward
- memReady  in  1  memory handshake completion for the current request
- memReq  out  1  memory request active
- adrSrc  out  1  memory address select: 0=PC, 1=ALU result register
- irWrite  out  1  instruction register load strobe
- pcUpdate  out  1  PC load strobe
- branch  out  1  conditional PC load (datapath ANDs with zero)
- regWrite  out  1  register file write strobe
- memWrite  out  1  data memory write enable
- resSrc  out  2  result mux: 00=ALU out reg, 01=data reg, 10=ALU result
- aluSrcA  out  2  00=PC, 01=oldPC, 10=rs1
- aluSrcB  out  2  00=rs2, 01=immediate, 10=constant 4
- aluOp  out  2  to aluDeco: 00=add, 01=sub, 10=funct-decoded
- immSrc  out  2  immediate format select
- state  out  4  current state encoding (debug)
- done  out  1  one-cycle pulse at instruction completion
- illegal  out  1  one-cycle pulse on unsupported opcode
- instret  out  32  retired instruction counter

Function
REQ-002 State encodings SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL return to FETCH on the next edge.
REQ-003 Transitions SHALL be: FETCH->DECODE only when memReady=1, otherwise FETCH is held.
REQ-004 DECODE SHALL go to MEMADR for op 0000011 (lw) or 0100011 (sw), EXECUTER for 0110011, EXECUTEI for 0010011, BEQ for 1100011, JAL for 1101111, and FETCH for any other op.
REQ-005 MEMADR SHALL go to MEMREAD for lw and MEMWRITE for sw.
REQ-006 MEMREAD->MEMWB and MEMWRITE->FETCH SHALL occur only when memReady=1, otherwise the state is held.
REQ-007 The remaining transitions SHALL be MEMWB->FETCH, EXECUTER->ALUWB, EXECUTEI->ALUWB, JAL->ALUWB, ALUWB->FETCH and BEQ->FETCH.
REQ-008 Outputs SHALL be Moore-decoded from state; unlisted selects are 00 and unlisted strobes are 0:
- FETCH: memReq=1, adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resSrc=10; irWrite=pcUpdate=memReady
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00
- MEMREAD: memReq=1, adrSrc=1, resSrc=00
- MEMWB: resSrc=01, regWrite=1
- MEMWRITE: memReq=1, adrSrc=1, memWrite=1
- EXECUTER: aluSrcA=10, aluSrcB=00, aluOp=10
- EXECUTEI: aluSrcA=10, aluSrcB=01, aluOp=10
- ALUWB: resSrc=00, regWrite=1
- BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, resSrc=00, branch=1
- JAL: aluSrcA=01, aluSrcB=10, aluOp=00, resSrc=00, pcUpdate=1
REQ-009 immSrc SHALL be combinational from op in every state: 0100011->01, 1100011->10, 1101111->11, all others->00.
REQ-010 memReq, adrSrc and memWrite SHALL remain stable while a memory state is held waiting for memReady.
REQ-011 done SHALL pulse in MEMWB, ALUWB, BEQ, and in MEMWRITE during the cycle memReady=1.
REQ-012 illegal SHALL pulse in DECODE when the opcode is unsupported; done SHALL NOT pulse for that instruction.
REQ-013 instret SHALL increment by 1 on each edge where done=1, wrapping 0xFFFFFFFF->0.
REQ-014 Instruction latencies with memReady tied to 1 SHALL be: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.

Reset
REQ-015 A rising edge with rstN=0 SHALL force state=FETCH and instret=0, regardless of the current state, including mid-instruction and mid-wait.
REQ-016 While rstN=0, all strobes (memReq, irWrite, pcUpdate, branch, regWrite, memWrite, done, illegal) SHALL be forced to 0 and all selects to 0.
REQ-017 The first cycle after rstN returns to 1 SHALL present FETCH outputs.

Verification
REQ-018 Scenario: memReady=1, op=0000011 -> states 0,1,2,3,4,0; regWrite=1 only in state 4; done at cycle 5; instret=1.
REQ-019 Scenario: sw with memReady low for 3 cycles in MEMWRITE -> state 5 held 4 cycles, memWrite=1 throughout; done only on the memReady cycle.
REQ-020 Scenario: op=1100011 -> states 0,1,9,0; branch=1 and aluOp=01 in state 9; immSrc=10.
REQ-021 Scenario: op=1101111 -> states 0,1,10,8,0; pcUpdate=1 in FETCH and JAL; regWrite=1 in state 8.
REQ-022 Scenario: op=1111111 -> DECODE->FETCH; illegal pulses once; instret unchanged.
REQ-023 Scenario: rstN=0 asserted in EXECUTER after 2 retired instructions -> next state 0, instret=0, no regWrite pulse.
